// File: rtl/renode_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// renode_ahb_arbiter
//   Round-robin arbiter and single-transfer sequencer. NumRequesters request
//   channels share one AHB-Lite manager port. Each accepted request becomes a
//   single NONSEQ transfer (address phase, then data phase). Both phases honour
//   hready wait states. The response is returned only to the granted requester.
//
// Ports
//   hclk, hresetn      bus clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is a one-hot pulse)
//   req_addr/write/size/wdata  packed per-requester request fields
//   rsp_valid          one-hot, one-cycle response pulse
//   rsp_rdata/error    shared response payload, qualified by rsp_valid
//   haddr..hwstrb      AHB-Lite manager outputs (registered)
//   hready/hresp/hrdata AHB-Lite subordinate inputs
// -----------------------------------------------------------------------------
module renode_ahb_arbiter #(
  parameter int NumRequesters = 4,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32
) (
  input  logic                                 hclk,
  input  logic                                 hresetn,
  input  logic [NumRequesters-1:0]             req_valid,
  output logic [NumRequesters-1:0]             req_ready,
  input  logic [NumRequesters*AddressWidth-1:0] req_addr,
  input  logic [NumRequesters-1:0]             req_write,
  input  logic [NumRequesters*3-1:0]           req_size,
  input  logic [NumRequesters*DataWidth-1:0]   req_wdata,
  output logic [NumRequesters-1:0]             rsp_valid,
  output logic [DataWidth-1:0]                 rsp_rdata,
  output logic                                 rsp_error,
  output logic [AddressWidth-1:0]              haddr,
  output logic [1:0]                           htrans,
  output logic                                 hwrite,
  output logic [2:0]                           hsize,
  output logic [2:0]                           hburst,
  output logic [DataWidth-1:0]                 hwdata,
  output logic [DataWidth/8-1:0]               hwstrb,
  input  logic                                 hready,
  input  logic                                 hresp,
  input  logic [DataWidth-1:0]                 hrdata
);

  localparam int StrbW = DataWidth / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int GntW  = $clog2(NumRequesters);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e                    state_q, state_d;
  logic [GntW-1:0]           gnt_q, last_gnt_q;
  logic [DataWidth-1:0]      wdata_q;
  logic [AddressWidth-1:0]   haddr_q;
  logic [1:0]                htrans_q;
  logic                      hwrite_q;
  logic [2:0]                hsize_q;
  logic [DataWidth-1:0]      hwdata_q;
  logic [StrbW-1:0]          hwstrb_q;
  logic [NumRequesters-1:0]  rsp_valid_q;
  logic [DataWidth-1:0]      rsp_rdata_q;
  logic                      rsp_error_q;

  // Unpacked views of the packed request buses, indexed by the grant.
  logic [AddressWidth-1:0] addr_arr  [NumRequesters];
  logic [2:0]              size_arr  [NumRequesters];
  logic [DataWidth-1:0]    wdata_arr [NumRequesters];

  for (genvar i = 0; i < NumRequesters; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AddressWidth +: AddressWidth];
    assign size_arr[i]  = req_size[i*3 +: 3];
    assign wdata_arr[i] = req_wdata[i*DataWidth +: DataWidth];
  end

  // Round-robin search starting just after the last requester served.
  logic            found;
  logic [GntW-1:0] gnt_idx, cand;
  logic            size_ok;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NumRequesters; i++) begin
      cand = GntW'((int'(last_gnt_q) + i) % NumRequesters);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    size_ok = (int'(size_arr[gnt_idx]) <= OffW);
  end

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic. An oversized request skips the bus entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (found) state_d = size_ok ? S_ADDR : S_RESP;
      S_ADDR: if (hready) state_d = S_DATA;
      S_DATA: if (hready) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: grant pulse and byte-lane strobe for the latched transfer.
  int               nbytes, lane_off;
  logic [StrbW-1:0] lane_strb;

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found) req_ready = NumRequesters'(1) << gnt_idx;
    nbytes    = 1 << hsize_q;
    // Lane offset is the address aligned down to the transfer size.
    lane_off  = int'(haddr_q[OffW-1:0]) & ~(nbytes - 1);
    lane_strb = StrbW'(((1 << nbytes) - 1) << lane_off);
  end

  // Datapath and registered bus/response outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      // NOTE: all storage, including the request latch, is reset so that a
      // transfer in flight at reset is dropped without any trace.
      gnt_q       <= '0;
      last_gnt_q  <= GntW'(NumRequesters - 1);
      wdata_q     <= '0;
      haddr_q     <= '0;
      htrans_q    <= HtransIdle;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hwdata_q    <= '0;
      hwstrb_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            gnt_q <= gnt_idx;
            if (size_ok) begin
              htrans_q <= HtransNonseq;
              haddr_q  <= addr_arr[gnt_idx];
              hwrite_q <= req_write[gnt_idx];
              hsize_q  <= size_arr[gnt_idx];
              wdata_q  <= wdata_arr[gnt_idx];
            end else begin
              rsp_valid_q <= NumRequesters'(1) << gnt_idx;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_ADDR: begin
          if (hready) begin
            htrans_q <= HtransIdle;
            if (hwrite_q) begin
              hwdata_q <= wdata_q;
              hwstrb_q <= lane_strb;
            end else begin
              hwstrb_q <= '0;
            end
          end
        end
        S_DATA: begin
          // hresp only counts on the hready=1 cycle of an ERROR response.
          if (hready) begin
            rsp_valid_q <= NumRequesters'(1) << gnt_q;
            rsp_error_q <= hresp;
            rsp_rdata_q <= (hwrite_q || hresp) ? '0 : hrdata;
            hwstrb_q    <= '0;
          end
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          last_gnt_q  <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = 3'b000;  // SINGLE only
  assign hwdata    = hwdata_q;
  assign hwstrb    = hwstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
